// File: rtl/hmc_rf_access_master.sv
// Queued request/response master driving the openHMC controller RF port, one access at a time.
// Optional define RF_ADDR_PRECHECK_EN rejects accesses that are illegal in the RF map without strobing the RF.
module hmc_rf_access_master #(
  parameter int HMC_RF_WWIDTH  = 64,
  parameter int HMC_RF_RWIDTH  = 64,
  parameter int HMC_RF_AWIDTH  = 4,
  parameter int LOG_REQ_DEPTH  = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     clk_hmc,
  input  logic                     res_hmc,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [HMC_RF_AWIDTH-1:0] req_address,
  input  logic [HMC_RF_WWIDTH-1:0] req_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_write,
  output logic [HMC_RF_RWIDTH-1:0] rsp_rdata,
  output logic                     rsp_invalid_address,
  output logic                     rsp_timeout,
  output logic [HMC_RF_AWIDTH-1:0] rf_address,
  output logic [HMC_RF_WWIDTH-1:0] rf_write_data,
  output logic                     rf_read_en,
  output logic                     rf_write_en,
  input  logic [HMC_RF_RWIDTH-1:0] rf_read_data,
  input  logic                     rf_invalid_address,
  input  logic                     rf_access_complete
);
  localparam int REQ_DEPTH = 2 ** LOG_REQ_DEPTH;
  localparam int CNT_W     = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state;

  logic [HMC_RF_AWIDTH-1:0] fifo_addr  [REQ_DEPTH];
  logic [HMC_RF_WWIDTH-1:0] fifo_wdata [REQ_DEPTH];
  logic                     fifo_write [REQ_DEPTH];
  logic [LOG_REQ_DEPTH-1:0] wr_ptr, rd_ptr;
  logic [LOG_REQ_DEPTH:0]   count, count_next;
  logic                     push, pop;
  logic                     head_write;
  logic [HMC_RF_AWIDTH-1:0] head_addr;
  logic [HMC_RF_WWIDTH-1:0] head_wdata;
  logic                     cmd_write;
  logic [CNT_W-1:0]         wait_cnt;

  assign push       = req_valid && req_ready;
  assign pop        = (state == IDLE) && (count != '0);
  assign head_write = fifo_write[rd_ptr];
  assign head_addr  = fifo_addr[rd_ptr];
  assign head_wdata = fifo_wdata[rd_ptr];

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + 1'b1;
    else if (!push && pop)
      count_next = count - 1'b1;
  end

  always_ff @(posedge clk_hmc) begin
    if (push) begin
      fifo_addr[wr_ptr]  <= req_address;
      fifo_wdata[wr_ptr] <= req_wdata;
      fifo_write[wr_ptr] <= req_write;
    end
  end

  // req_ready is registered from the next occupancy so it is glitch-free to the host
  always_ff @(posedge clk_hmc) begin
    if (res_hmc) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      req_ready <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count     <= count_next;
      req_ready <= (count_next != (LOG_REQ_DEPTH+1)'(REQ_DEPTH));
    end
  end

`ifdef RF_ADDR_PRECHECK_EN
  function automatic logic access_legal(input logic wr, input logic [HMC_RF_AWIDTH-1:0] a);
    if (wr)
      return (a == HMC_RF_AWIDTH'(2)) || (a == HMC_RF_AWIDTH'(8)) ||
             ((a >= HMC_RF_AWIDTH'(13)) && (a <= HMC_RF_AWIDTH'(15)));
    return a != HMC_RF_AWIDTH'(8);
  endfunction
`endif

  always_ff @(posedge clk_hmc) begin
    if (res_hmc) begin
      state               <= IDLE;
      cmd_write           <= 1'b0;
      wait_cnt            <= '0;
      rf_address          <= '0;
      rf_write_data       <= '0;
      rf_read_en          <= 1'b0;
      rf_write_en         <= 1'b0;
      rsp_valid           <= 1'b0;
      rsp_write           <= 1'b0;
      rsp_rdata           <= '0;
      rsp_invalid_address <= 1'b0;
      rsp_timeout         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            cmd_write     <= head_write;
            rf_address    <= head_addr;
            rf_write_data <= head_wdata;
`ifdef RF_ADDR_PRECHECK_EN
            if (!access_legal(head_write, head_addr)) begin
              rsp_valid           <= 1'b1;
              rsp_write           <= head_write;
              rsp_rdata           <= '0;
              rsp_invalid_address <= 1'b1;
              rsp_timeout         <= 1'b0;
              state               <= RESP;
            end else begin
              rf_read_en  <= !head_write;
              rf_write_en <= head_write;
              state       <= ISSUE;
            end
`else
            rf_read_en  <= !head_write;
            rf_write_en <= head_write;
            state       <= ISSUE;
`endif
          end
        end
        ISSUE: begin
          rf_read_en  <= 1'b0;
          rf_write_en <= 1'b0;
          wait_cnt    <= '0;
          state       <= WAIT;
        end
        // A completion in the same cycle as the last timeout slot still counts as a completion
        WAIT: begin
          if (rf_access_complete) begin
            rsp_valid           <= 1'b1;
            rsp_write           <= cmd_write;
            rsp_rdata           <= cmd_write ? '0 : rf_read_data;
            rsp_invalid_address <= rf_invalid_address;
            rsp_timeout         <= 1'b0;
            state               <= RESP;
          end else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            rsp_valid           <= 1'b1;
            rsp_write           <= cmd_write;
            rsp_rdata           <= '0;
            rsp_invalid_address <= 1'b0;
            rsp_timeout         <= 1'b1;
            state               <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid           <= 1'b0;
            rsp_write           <= 1'b0;
            rsp_rdata           <= '0;
            rsp_invalid_address <= 1'b0;
            rsp_timeout         <= 1'b0;
            state               <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hmc_rf_access_master.sv
// Scoreboard bench for hmc_rf_access_master: stimulus queues expected responses, a monitor checks them,
// and a small RF model answers strobes and checks strobe protocol.
module tb_hmc_rf_access_master;
  logic        clk_hmc;
  logic        res_hmc;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [3:0]  req_address;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_write;
  logic [63:0] rsp_rdata;
  logic        rsp_invalid_address;
  logic        rsp_timeout;
  logic [3:0]  rf_address;
  logic [63:0] rf_write_data;
  logic        rf_read_en;
  logic        rf_write_en;
  logic [63:0] rf_read_data;
  logic        rf_invalid_address;
  logic        rf_access_complete;

`ifdef RF_ADDR_PRECHECK_EN
  localparam bit PRECHECK = 1'b1;
`else
  localparam bit PRECHECK = 1'b0;
`endif

  typedef struct {
    bit          write;
    logic [63:0] rdata;
    bit          inv;
    bit          to;
    int          lat;
    bit          strobed;
  } exp_t;

  // mode 0: complete next cycle, 1: complete with invalid flag, 2: never complete
  typedef struct {
    bit          write;
    logic [3:0]  addr;
    logic [63:0] wdata;
    int          mode;
    logic [63:0] rdata;
  } rf_t;

  exp_t exp_q[$];
  rf_t  rf_q[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int strobe_count = 0;
  int expected_strobes = 0;
  int accept_strobed = 0;
  int dropped_strobes = 0;
  int last_strobe_cyc = 0;
  int stray_req = 0;
  int stray_done = 0;

  hmc_rf_access_master dut (
    .clk_hmc             (clk_hmc),
    .res_hmc             (res_hmc),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_write           (req_write),
    .req_address         (req_address),
    .req_wdata           (req_wdata),
    .rsp_valid           (rsp_valid),
    .rsp_ready           (rsp_ready),
    .rsp_write           (rsp_write),
    .rsp_rdata           (rsp_rdata),
    .rsp_invalid_address (rsp_invalid_address),
    .rsp_timeout         (rsp_timeout),
    .rf_address          (rf_address),
    .rf_write_data       (rf_write_data),
    .rf_read_en          (rf_read_en),
    .rf_write_en         (rf_write_en),
    .rf_read_data        (rf_read_data),
    .rf_invalid_address  (rf_invalid_address),
    .rf_access_complete  (rf_access_complete)
  );

  initial begin
    clk_hmc = 1'b0;
    forever #5 clk_hmc = ~clk_hmc;
  end

  always @(posedge clk_hmc) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  function automatic bit bench_legal(input bit wr, input logic [3:0] a);
    if (wr)
      return (a == 4'h2) || (a == 4'h8) || (a == 4'hD) || (a == 4'hE) || (a == 4'hF);
    return a != 4'h8;
  endfunction

  // Called on a negedge; returns on the negedge after the request was taken
  task automatic applyStimulus(input bit wr, input logic [3:0] addr, input logic [63:0] wdata,
                               input int mode, input logic [63:0] rf_data, input int lat);
    exp_t e;
    rf_t  r;
    int   guard = 0;
    bit   strobe = !PRECHECK || bench_legal(wr, addr);
    e.write   = wr;
    e.strobed = strobe;
    if (strobe) begin
      r.write = wr; r.addr = addr; r.wdata = wdata; r.mode = mode; r.rdata = rf_data;
      rf_q.push_back(r);
      expected_strobes++;
      e.inv   = (mode == 1);
      e.to    = (mode == 2);
      e.rdata = (wr || mode == 2) ? 64'd0 : rf_data;
      e.lat   = lat;
    end else begin
      e.inv = 1'b1; e.to = 1'b0; e.rdata = 64'd0; e.lat = 0;
    end
    exp_q.push_back(e);
    while (req_ready !== 1'b1 && guard < 200) begin
      @(negedge clk_hmc);
      guard++;
    end
    if (req_ready !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL req_accept: actual req_ready=%b, required 1 within 200 cycles", req_ready);
    end else begin
      req_valid   = 1'b1;
      req_write   = wr;
      req_address = addr;
      req_wdata   = wdata;
      @(negedge clk_hmc);
      req_valid   = 1'b0;
    end
  endtask

  task automatic waitDrain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk_hmc);
      n++;
    end
    checkOutput("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  // RF model: answers each strobe one cycle later and checks the strobe protocol
  initial begin
    rf_t it;
    rf_t pend_it;
    bit  pend = 1'b0;
    forever begin
      @(negedge clk_hmc);
      rf_access_complete = 1'b0;
      rf_invalid_address = 1'b0;
      rf_read_data       = 64'd0;
      if (pend) begin
        rf_access_complete = 1'b1;
        rf_invalid_address = (pend_it.mode == 1);
        rf_read_data       = pend_it.rdata;
        pend = 1'b0;
      end else if (stray_req != stray_done) begin
        stray_done++;
        rf_access_complete = 1'b1;
        rf_invalid_address = 1'b1;
        rf_read_data       = 64'hBAD0_BAD0_BAD0_BAD0;
      end
      if (rf_read_en === 1'b1 || rf_write_en === 1'b1) begin
        checkOutput("rd_wr_exclusive", 64'(rf_read_en & rf_write_en), 64'd0);
        checkOutput("strobe_overlap", 64'(strobe_count), 64'(accept_strobed + dropped_strobes));
        strobe_count++;
        last_strobe_cyc = cyc;
        if (rf_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL extra_strobe: actual strobe at addr 0x%0h, required none", rf_address);
        end else begin
          it = rf_q.pop_front();
          checkOutput("strobe_write_en", 64'(rf_write_en), 64'(it.write));
          checkOutput("rf_address", 64'(rf_address), 64'(it.addr));
          if (it.write)
            checkOutput("rf_write_data", rf_write_data, it.wdata);
          if (it.mode != 2) begin
            pend    = 1'b1;
            pend_it = it;
          end
        end
      end
    end
  end

  // Response monitor: compares every accepted response against the scoreboard head
  initial begin
    exp_t e;
    bit   prev_valid = 1'b0;
    int   first_valid_cyc = 0;
    forever begin
      @(negedge clk_hmc);
      #1;
      if (rsp_valid === 1'b1 && !prev_valid)
        first_valid_cyc = cyc;
      prev_valid = (rsp_valid === 1'b1);
      if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_rsp: actual rsp_valid=1, required no response");
        end else begin
          e = exp_q.pop_front();
          if (e.strobed)
            accept_strobed++;
          checkOutput("rsp_write", 64'(rsp_write), 64'(e.write));
          checkOutput("rsp_rdata", rsp_rdata, e.rdata);
          checkOutput("rsp_invalid_address", 64'(rsp_invalid_address), 64'(e.inv));
          checkOutput("rsp_timeout", 64'(rsp_timeout), 64'(e.to));
          if (e.lat != 0)
            checkOutput("strobe_to_rsp_latency", 64'(first_valid_cyc - last_strobe_cyc), 64'(e.lat));
        end
      end
    end
  end

  initial begin
    int s0;
    int n;
    res_hmc     = 1'b1;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_address = 4'h0;
    req_wdata   = 64'd0;
    rsp_ready   = 1'b1;

    repeat (3) @(negedge clk_hmc);
    checkOutput("reset_req_ready", 64'(req_ready), 64'd0);
    checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("reset_strobes", 64'({rf_read_en, rf_write_en}), 64'd0);
    checkOutput("reset_rf_address", 64'(rf_address), 64'd0);
    res_hmc = 1'b0;
    @(negedge clk_hmc);
    checkOutput("post_reset_req_ready", 64'(req_ready), 64'd1);

    $display("[TB] basic read, write and invalid-address accesses");
    applyStimulus(1'b0, 4'h2, 64'd0, 0, 64'hDEAD_BEEF, 2);
    waitDrain();
    applyStimulus(1'b1, 4'h8, 64'h55, 0, 64'hFFFF_0000_1111_2222, 2);
    waitDrain();
    applyStimulus(1'b1, 4'h0, 64'h99, 1, 64'd0, 2);
    waitDrain();
    applyStimulus(1'b0, 4'hD, 64'd0, 0, 64'h0123_4567_89AB_CDEF, 2);
    waitDrain();

    $display("[TB] timeout with late completion");
    rsp_ready = 1'b0;
    applyStimulus(1'b0, 4'h3, 64'd0, 2, 64'd0, 17);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 40) begin
      @(negedge clk_hmc);
      n++;
    end
    checkOutput("timeout_rsp_valid", 64'(rsp_valid), 64'd1);
    stray_req++;
    repeat (3) @(negedge clk_hmc);
    rsp_ready = 1'b1;
    waitDrain();
    stray_req++;
    repeat (3) @(negedge clk_hmc);
    applyStimulus(1'b0, 4'hE, 64'd0, 0, 64'hCAFE, 2);
    waitDrain();

    $display("[TB] five back-to-back requests with response back-pressure");
    s0 = strobe_count;
    rsp_ready = 1'b0;
    applyStimulus(1'b1, 4'h2, 64'h11, 0, 64'd0, 0);
    applyStimulus(1'b0, 4'hD, 64'd0, 0, 64'hA1, 0);
    applyStimulus(1'b1, 4'hE, 64'h22, 0, 64'd0, 0);
    applyStimulus(1'b0, 4'hF, 64'd0, 0, 64'hA2, 0);
    applyStimulus(1'b0, 4'h2, 64'd0, 0, 64'hA3, 0);
    checkOutput("full_req_ready", 64'(req_ready), 64'd0);
    repeat (10) @(negedge clk_hmc);
    checkOutput("held_req_ready", 64'(req_ready), 64'd0);
    checkOutput("held_strobe_count", 64'(strobe_count - s0), 64'd1);
    rsp_ready = 1'b1;
    waitDrain();

    $display("[TB] reset while waiting on the RF");
    s0 = strobe_count;
    applyStimulus(1'b0, 4'h2, 64'd0, 2, 64'd0, 0);
    applyStimulus(1'b0, 4'hD, 64'd0, 0, 64'h77, 0);
    n = 0;
    while (strobe_count == s0 && n < 20) begin
      @(negedge clk_hmc);
      n++;
    end
    checkOutput("reset_test_strobe", 64'(strobe_count - s0), 64'd1);
    repeat (3) @(negedge clk_hmc);
    res_hmc = 1'b1;
    expected_strobes -= rf_q.size();
    rf_q.delete();
    exp_q.delete();
    dropped_strobes++;
    @(negedge clk_hmc);
    checkOutput("abort_strobes", 64'({rf_read_en, rf_write_en}), 64'd0);
    checkOutput("abort_rf_address", 64'(rf_address), 64'd0);
    checkOutput("abort_rf_write_data", rf_write_data, 64'd0);
    checkOutput("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("abort_rsp_flags", 64'({rsp_write, rsp_invalid_address, rsp_timeout}), 64'd0);
    checkOutput("abort_rsp_rdata", rsp_rdata, 64'd0);
    checkOutput("abort_req_ready", 64'(req_ready), 64'd0);
    res_hmc = 1'b0;
    @(negedge clk_hmc);
    checkOutput("recover_req_ready", 64'(req_ready), 64'd1);
    repeat (20) @(negedge clk_hmc);
    checkOutput("no_strobe_after_reset", 64'(strobe_count - s0), 64'd1);
    applyStimulus(1'b1, 4'hF, 64'h77, 0, 64'd0, 2);
    waitDrain();

    checkOutput("strobe_total", 64'(strobe_count), 64'(expected_strobes));
    checkOutput("rf_items_left", 64'(rf_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/hmc_rf_access_master.md
Name: hmc_rf_access_master

Overview:
Register-file master that feeds the openHMC controller RF port (rf_address/rf_read_en/rf_write_en/rf_write_data) from a queued request/response stream. Issues exactly one RF access at a time and guarantees the RF protocol: single-cycle strobes, never read and write together. Sits between the host/config logic and the controller RF, in the clk_hmc domain. Returns read data, invalid-address and timeout status per request.

Parameters:
HMC_RF_WWIDTH, 64, RF write data width
HMC_RF_RWIDTH, 64, RF read data width
HMC_RF_AWIDTH, 4, RF address width
LOG_REQ_DEPTH, 2, request FIFO depth = 2**LOG_REQ_DEPTH entries
TIMEOUT_CYCLES, 16, max cycles after strobe to wait for rf_access_complete (>=2)

Ports:
clk_hmc  in  1  clock, all logic on rising edge
res_hmc  in  1  synchronous, active-high reset
req_valid  in  1  request valid
req_ready  out  1  request FIFO not full
req_write  in  1  1=write, 0=read
req_address  in  HMC_RF_AWIDTH  RF address
req_wdata  in  HMC_RF_WWIDTH  write data
rsp_valid  out  1  response valid
rsp_ready  in  1  response accepted
rsp_write  out  1  echo of req_write
rsp_rdata  out  HMC_RF_RWIDTH  read data (0 for writes/errors)
rsp_invalid_address  out  1  RF flagged invalid address
rsp_timeout  out  1  no access_complete within TIMEOUT_CYCLES
rf_address  out  HMC_RF_AWIDTH  RF address
rf_write_data  out  HMC_RF_WWIDTH  RF write data
rf_read_en  out  1  read strobe
rf_write_en  out  1  write strobe
rf_read_data  in  HMC_RF_RWIDTH  RF read data
rf_invalid_address  in  1  RF invalid-address flag
rf_access_complete  in  1  RF access done

Behaviour:
- Reset (res_hmc=1 at clock edge): FIFO empty, state IDLE, all outputs 0 except req_ready=0 during reset, 1 first cycle after.
- Request FIFO: push on req_valid&&req_ready; req_ready = !full. Push when full impossible. Push and pop in same cycle allowed, including when full (req_ready stays 0 that cycle; registered).
- FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE: if FIFO non-empty, pop head into command registers, go ISSUE.
- ISSUE: for exactly one cycle drive rf_read_en=!write or rf_write_en=write; rf_address/rf_write_data driven from command regs, held stable ISSUE through WAIT. Timeout counter cleared. Go WAIT.
- WAIT: strobes 0. On rf_access_complete: capture rf_read_data (reads only; writes capture 0), rf_invalid_address; go RESP. Counter increments each WAIT cycle; if counter reaches TIMEOUT_CYCLES without complete: rsp_timeout=1, rdata=0, invalid=0, go RESP.
- rf_access_complete outside WAIT ignored (no state change, no capture).
- RESP: rsp_valid=1, all rsp_* stable until rsp_ready; on rsp_valid&&rsp_ready go IDLE, rsp_valid=0 next cycle.
- Nominal latency (RF completes 1 cycle after strobe): pop at cycle N, strobe N+1, complete N+2, rsp_valid N+3.
- Invariant: rf_read_en&&rf_write_en never 1; at most one strobe per request; no new strobe before prior response accepted.
- Reset mid-operation: aborts access, drops queued requests and pending response, no further strobes.

Optional Feature:
RF_ADDR_PRECHECK_EN: when defined, IDLE checks popped command against RF map (writable: 0x2,0x8,0xD,0xE,0xF; readable: all except 0x8). Illegal access skips ISSUE/WAIT, no strobe, goes RESP with rsp_invalid_address=1, rdata=0. Undefined: every request goes to RF; invalid flag only from rf_invalid_address.

Test Plan:
- Read addr 0x2, RF completes 1 cycle after strobe with data 0xDEAD_BEEF -> one-cycle rf_read_en, rsp_valid 3 cycles after pop, rsp_rdata=0xDEAD_BEEF, flags 0.
- Write addr 0x8 data 0x55 -> one-cycle rf_write_en with rf_write_data=0x55, rsp_write=1, rsp_rdata=0.
- Write addr 0x0, RF asserts invalid_address with complete -> rsp_invalid_address=1; with RF_ADDR_PRECHECK_EN, no strobe, same response.
- RF never completes -> rsp_timeout=1 after 16 WAIT cycles; late complete ignored; next request proceeds normally.
- Push 5 requests back-to-back, rsp_ready=0 for 10 cycles -> req_ready=0 after 4 queued + 1 in flight, single strobe only, responses in order after release.
- res_hmc=1 during WAIT -> next cycle all outputs 0, FIFO empty, pending response dropped.
